// File: rtl/codec_reg_pkg.sv
// Shared definitions for the codec control-port target.
// Holds the FSM state type, the register-file geometry and the power-on
// register defaults, so the RTL and anything else that needs them agree.
package codec_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEV_BYTE = 3'd1,
    ST_DEV_ACK  = 3'd2,
    ST_HI_BYTE  = 3'd3,
    ST_HI_ACK   = 3'd4,
    ST_LO_BYTE  = 3'd5,
    ST_LO_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  localparam int NUM_REGS = 10;

  localparam logic [3:0] RESET_REG_ADDR = 4'hF;

  // Element [0] is R0; the list reads R9 down to R0 from left to right.
  localparam logic [NUM_REGS-1:0][8:0] REG_DEFAULTS = {
    9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
    9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
  };

endpackage

// File: rtl/i2c_cond_detect.sv
// I2C line conditioner: synchronizes SCL/SDA into the clk_50 domain and
// produces single-cycle SCL rise/fall and START/STOP pulses.
// START/STOP are only flagged while SCL was high in both the current and the
// previous sample, so they can never coincide with an SCL edge; an SDA change
// that lands together with an SCL rise is therefore seen as data.
module i2c_cond_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50,
  input  logic ar,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Synchronizer chains plus one delay flop per line for edge detection;
  // lines reset to the idle-high bus level.
  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  scl_d & ~sda_s &  sda_d;
  assign stop_det  =  scl_s &  scl_d &  sda_s & ~sda_d;

endmodule

// File: rtl/codec_reg_target.sv
// Write-only I2C target modelling the audio codec control port.
// Accepts one {addr[6:0], data[8:0]} word per transaction after the device
// byte, commits it to a 10 x 9-bit shadow register file and strobes wr_stb.
// Optional feature macro: CODEC_RESET_REG_EN -- when defined, a write to
// address 15 restores all registers to their defaults; otherwise address 15
// is treated as an unimplemented register.
module codec_reg_target
  import codec_reg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_50,
  input  logic       ar,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_stb,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       codec_active,
  output logic       busy,
  output logic       addr_err
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  state_t     state;
  logic [7:0] shreg;
  logic [7:0] hi_byte;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       rst_pend;
  logic [8:0] regs [NUM_REGS];

  logic [6:0] commit_addr;
  logic [8:0] commit_data;
  logic       in_byte;

  i2c_cond_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cond (
    .clk_50    (clk_50),
    .ar        (ar),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // The word being committed: address from the high byte, data bit 8 from the
  // high byte LSB and the low byte completed by the bit sampled this cycle.
  assign commit_addr = hi_byte[7:1];
  assign commit_data = {hi_byte[0], shreg[6:0], sda_s};
  assign in_byte     = (state == ST_DEV_BYTE) || (state == ST_HI_BYTE) ||
                       (state == ST_LO_BYTE);

  // Protocol FSM, shift register, commit logic and register file.
  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      hi_byte   <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      rst_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      addr_err  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_DEFAULTS[i];
    end else begin
      wr_stb   <= 1'b0;
      addr_err <= 1'b0;
      if (rst_pend) begin
        rst_pend <= 1'b0;
        for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_DEFAULTS[i];
      end
      if (start_det) begin
        state     <= ST_DEV_BYTE;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (scl_rise) begin
        if (in_byte) begin
          shreg   <= {shreg[6:0], sda_s};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            if (state == ST_LO_BYTE) begin
              if (commit_addr < 7'(NUM_REGS)) begin
                regs[commit_addr[3:0]] <= commit_data;
                wr_stb  <= 1'b1;
                wr_addr <= commit_addr;
                wr_data <= commit_data;
              end
`ifdef CODEC_RESET_REG_EN
              else if (commit_addr == {3'b000, RESET_REG_ADDR}) begin
                wr_stb   <= 1'b1;
                wr_addr  <= commit_addr;
                wr_data  <= commit_data;
                rst_pend <= 1'b1;
              end
`endif
              else begin
                addr_err <= 1'b1;
              end
            end
          end
        end
      end else if (scl_fall) begin
        case (state)
          ST_DEV_BYTE: if (byte_done) begin
            byte_done <= 1'b0;
            if (shreg == {DEV_ADDR, 1'b0}) begin
              state  <= ST_DEV_ACK;
              sda_oe <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state <= ST_IGNORE;
            end
          end
          ST_HI_BYTE: if (byte_done) begin
            byte_done <= 1'b0;
            hi_byte   <= shreg;
            state     <= ST_HI_ACK;
            sda_oe    <= 1'b1;
          end
          ST_LO_BYTE: if (byte_done) begin
            byte_done <= 1'b0;
            state     <= ST_LO_ACK;
            sda_oe    <= 1'b1;
          end
          ST_DEV_ACK: begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_HI_BYTE;
          end
          ST_HI_ACK: begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_LO_BYTE;
          end
          ST_LO_ACK: begin
            sda_oe <= 1'b0;
            state  <= ST_IGNORE;
          end
          default: ;
        endcase
      end
    end
  end

  // Combinational register-file read port; unimplemented addresses read 0.
  always_comb begin
    rd_data = '0;
    if (rd_addr < 4'(NUM_REGS)) rd_data = regs[rd_addr];
  end

  assign codec_active = regs[9][0];

endmodule

// File: tb/tb_codec_reg_target.sv
// Self-checking bench for codec_reg_target: bit-banged I2C master, directed
// scenarios plus randomized transactions checked against a register-level
// reference model. Honors CODEC_RESET_REG_EN the same way as the design.
module tb_codec_reg_target;

  logic       clk_50 = 1'b0;
  logic       ar = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_stb;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic [3:0] rd_addr = '0;
  logic [8:0] rd_data;
  logic       codec_active;
  logic       busy;
  logic       addr_err;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         stb_seen = 0;
  int         err_seen = 0;
  logic [6:0] last_addr = '0;
  logic [8:0] last_data = '0;

  logic [8:0] model [10];
  logic [8:0] defaults [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  logic       acks [5];

  codec_reg_target dut (
    .clk_50       (clk_50),
    .ar           (ar),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .sda_oe       (sda_oe),
    .wr_stb       (wr_stb),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .codec_active (codec_active),
    .busy         (busy),
    .addr_err     (addr_err)
  );

  // 50 MHz system clock.
  always #10 clk_50 = ~clk_50;

  // Open-drain wired-AND of master and target on SDA.
  assign sda_in = sda_m & ~sda_oe;

  // Count strobe cycles and capture the write report, sampled mid-cycle.
  always @(negedge clk_50) begin
    if (ar) begin
      if (wr_stb) begin
        stb_seen  = stb_seen + 1;
        last_addr = wr_addr;
        last_data = wr_data;
      end
      if (addr_err) err_seen = err_seen + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_50);
  endtask

  task automatic i2cStart(input int q);
    waitCycles(q); sda_m = 1'b1;
    waitCycles(q); scl_in = 1'b1;
    waitCycles(q); sda_m = 1'b0;
    waitCycles(q); scl_in = 1'b0;
  endtask

  task automatic i2cStop(input int q);
    waitCycles(q); sda_m = 1'b0;
    waitCycles(q); scl_in = 1'b1;
    waitCycles(q); sda_m = 1'b1;
    waitCycles(2 * q);
  endtask

  task automatic sendBit(input logic b, input int q);
    waitCycles(q); sda_m = b;
    waitCycles(q); scl_in = 1'b1;
    waitCycles(2 * q); scl_in = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int q, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(b[i], q);
    waitCycles(q); sda_m = 1'b1;
    waitCycles(q); scl_in = 1'b1;
    waitCycles(q); ack = sda_oe;
    waitCycles(q); scl_in = 1'b0;
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 10; i++) begin
      rd_addr = 4'(i);
      #1;
      checkOutput($sformatf("%s_R%0d", tag, i), 32'(rd_data), 32'(model[i]));
    end
    checkOutput({tag, "_codec_active"}, 32'(codec_active), 32'(model[9][0]));
  endtask

  // One full transaction followed by a comparison against the model.
  task automatic applyStimulus(input string tag, input logic [7:0] dev,
                               input logic [15:0] word, input int nbytes,
                               input int q);
    logic [7:0] bytes [5];
    logic [6:0] a;
    logic [8:0] d;
    int         stb0, err0, exp_stb, exp_err;
    logic [6:0] exp_addr;
    logic [8:0] exp_data;
    bytes[0] = dev; bytes[1] = word[15:8]; bytes[2] = word[7:0];
    bytes[3] = 8'(word[7:0] ^ 8'h5A); bytes[4] = 8'hFF;
    stb0 = stb_seen; err0 = err_seen;
    exp_stb = 0; exp_err = 0; exp_addr = last_addr; exp_data = last_data;
    a = word[15:9]; d = word[8:0];
    if (dev == 8'h34) begin
      if (a < 7'd10) begin
        model[a[3:0]] = d; exp_stb = 1; exp_addr = a; exp_data = d;
      end
`ifdef CODEC_RESET_REG_EN
      else if (a == 7'd15) begin
        for (int i = 0; i < 10; i++) model[i] = defaults[i];
        exp_stb = 1; exp_addr = a; exp_data = d;
      end
`endif
      else exp_err = 1;
    end
    i2cStart(q);
    for (int k = 0; k < nbytes; k++) sendByte(bytes[k], q, acks[k]);
    i2cStop(q);
    waitCycles(8);
    for (int k = 0; k < nbytes; k++)
      checkOutput($sformatf("%s_ack%0d", tag, k), 32'(acks[k]),
                  32'((dev == 8'h34) && (k < 3)));
    checkOutput({tag, "_stb_count"}, 32'(stb_seen - stb0), 32'(exp_stb));
    checkOutput({tag, "_err_count"}, 32'(err_seen - err0), 32'(exp_err));
    if (exp_stb != 0) begin
      checkOutput({tag, "_wr_addr"}, 32'(last_addr), 32'(exp_addr));
      checkOutput({tag, "_wr_data"}, 32'(last_data), 32'(exp_data));
    end
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_sda_oe_idle"}, 32'(sda_oe), 32'd0);
    checkRegs(tag);
  endtask

  initial begin
    logic       ack;
    int         stb0;
    logic [7:0] dev;
    logic [6:0] a;
    logic [15:0] w;
    for (int i = 0; i < 10; i++) model[i] = defaults[i];

    // Reset state.
    waitCycles(3);
    #1;
    checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst_wr_stb", 32'(wr_stb), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
    @(negedge clk_50); ar = 1'b1;
    waitCycles(4);
    checkRegs("reset");

    // Directed scenarios.
    applyStimulus("r9_100k", 8'h34, 16'h1201, 3, 125);
    applyStimulus("bad_dev", 8'h36, 16'h0C55, 3, 6);
    applyStimulus("after_bad", 8'h34, 16'h001D, 3, 6);
    applyStimulus("read_bit", 8'h35, 16'h0203, 3, 6);
    applyStimulus("addr13", 8'h34, 16'h1A00, 3, 7);
    applyStimulus("extra_byte", 8'h34, 16'h0A33, 5, 5);
    applyStimulus("r6_write", 8'h34, 16'h0C02, 3, 8);
    applyStimulus("addr15", 8'h34, 16'h1E00, 3, 8);

    // Reset in the middle of the low byte.
    stb0 = stb_seen;
    i2cStart(6);
    sendByte(8'h34, 6, ack);
    checkOutput("midrst_dev_ack", 32'(ack), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd1);
    sendByte(8'h0E, 6, ack);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 6);
    waitCycles(3);
    ar = 1'b0;
    #1;
    checkOutput("midrst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("midrst_busy_rst", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) model[i] = defaults[i];
    waitCycles(4);
    @(negedge clk_50); ar = 1'b1;
    i2cStop(6);
    waitCycles(8);
    checkOutput("midrst_no_stb", 32'(stb_seen - stb0), 32'd0);
    checkRegs("midrst");
    applyStimulus("post_rst", 8'h34, 16'h0E1F, 3, 6);

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      dev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
      a   = ($urandom_range(0, 9) < 7) ? 7'($urandom_range(0, 9))
                                       : 7'($urandom_range(10, 127));
      w   = {a, 9'($urandom)};
      applyStimulus($sformatf("rand%0d", n), dev, w,
                    $urandom_range(3, 4), $urandom_range(5, 9));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/codec_reg_target.md
# codec_reg_target

I2C write-only target that models the audio codec's control port. It decodes the 3-byte codec configuration writes (device byte, then a 16-bit word) that the setup logic issues through the I2C master. Each write is committed into a 9-bit-per-register shadow register file, and each accepted write is reported on a one-cycle strobe. It sits on the SCL/SDA pins in place of, or alongside, the codec, for board bring-up and for closed-loop simulation of the configuration path.

## Interface
Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address (address byte 8'h34 = write).
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (≥2).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- ar  in  1  reset, asynchronous, active-low.
- scl_in  in  1  I2C clock, asynchronous.
- sda_in  in  1  I2C data, asynchronous.
- sda_oe  out  1  1 = pull SDA low (ACK); pad is open-drain.
- wr_stb  out  1  one-cycle pulse per committed register write.
- wr_addr  out  7  register address of the last write.
- wr_data  out  9  data of the last write.
- rd_addr  in  4  register file read address.
- rd_data  out  9  register file contents at rd_addr, combinational.
- codec_active  out  1  bit 0 of register 9.
- busy  out  1  high from START to STOP while addressed.
- addr_err  out  1  one-cycle pulse on a write to an unimplemented register (10–14).

## Operation
- SCL and SDA pass through SYNC_STAGES flops, then a 1-flop edge detector; all decoding uses the synchronized versions only.
- START = SDA falls while SCL is high. STOP = SDA rises while SCL is high. Both are recognized in any state. START (including repeated START) enters DEV_BYTE. STOP enters IDLE and releases sda_oe.
- States:
  - IDLE
  - DEV_BYTE: shifts bits on SCL rise, MSB first.
  - DEV_ACK: on a match to {DEV_ADDR,0} → HI_BYTE with ACK. On mismatch or the R/W bit = 1 → IGNORE with no ACK.
  - HI_BYTE → HI_ACK → LO_BYTE → LO_ACK: all bytes ACKed.
  - IGNORE: sda_oe stays 0 until START or STOP.
- The 16-bit word is {addr[6:0], data[8:0]}. Examples: 16'h0c02 → R6 = 9'h002; 16'h1201 → R9 = 9'h001; 16'h001d → R0 = 9'h01D.
- Commit happens on the SCL rise that samples bit 0 of the low byte:
  - Address 0–9: write the register and pulse wr_stb.
  - Address 10–14: no write; pulse addr_err. The byte is still ACKed.
  - Address 15: reset handling, see Configuration.
  - Address >15: same as 10–14.
- After LO_ACK, any further byte in the same transaction is NACKed (state IGNORE). Only one word per transaction is accepted.
- Register defaults on reset, in order R0..R9: 097, 097, 079, 079, 00A, 008, 09F, 00A, 000, 000.
- Reset values: sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, addr_err=0, state IDLE, registers at defaults. Reset asserted mid-transaction aborts it immediately with no partial write, and SDA is released asynchronously.

## Timing
- SCL edge to internal detection: SYNC_STAGES+1 clk_50 cycles.
- wr_stb, wr_addr, wr_data and the register update all become visible SYNC_STAGES+2 cycles after the committing SCL rise.
- rd_data reflects the new value from the cycle wr_stb is high.
- sda_oe rises on the detected SCL fall that ends bit 0 of each ACKed byte. It falls on the detected SCL fall that ends the ACK bit.
- Minimum supported SCL period is 16 clk_50 cycles. At the 400 kHz bus rate the period is 125 cycles.
- A START/STOP and an SCL edge cannot be detected in the same cycle. If an SDA change and an SCL rise land in the same synchronized sample, the SCL rise is processed and the SDA change is treated as data.

## Configuration
- CODEC_RESET_REG_EN defined:
  - A committed write to address 15 restores all registers to their defaults one cycle after the commit.
  - wr_stb pulses with wr_addr=15 and wr_data taken from the written data.
  - codec_active drops to 0.
- CODEC_RESET_REG_EN undefined: address 15 is handled like 10–14 (addr_err pulse, no write).

## Structure
- Package codec_reg_pkg holds:
  - The state enum.
  - The register-count constant NUM_REGS=10.
  - The reset-register address constant 4'hF.
  - The default-value array.
- One sub-module, i2c_cond_detect: input synchronizers, SCL rise/fall, START/STOP pulses. It is instantiated once.
- The FSM, shift register and register file live in codec_reg_target.

## Test plan
- Reset, then read R0–R9 → 097, 097, 079, 079, 00A, 008, 09F, 00A, 000, 000; sda_oe=0.
- Write 8'h34, 8'h12, 8'h01 at 100 kHz → three ACKs, one wr_stb with wr_addr=7'h09 and wr_data=9'h001, codec_active=1.
- Send address byte 8'h36 → no ACK on any byte, no wr_stb, and the next transaction to 8'h34 works normally.
- Write word 16'h1A00 (address 13) → ACKs, one addr_err pulse, register file unchanged.
- Write R6=9'h002, then word 16'h1E00 → with CODEC_RESET_REG_EN R6 reads 09F; without it R6 reads 002 and addr_err pulses.
- Assert ar low during the low byte of a write → sda_oe=0 immediately, no wr_stb; the following full transaction commits correctly.
